mem_arbiter: RTL

//  Owns the single byte-wide RAM/IO port and shares it between instruction fetch (IF) and the

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the shared RAM/IO port: instruction fetch vs load/store buffer.
// Each request becomes 1/2/4 little-endian byte transfers; IO writes honour io_buffer_full.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE     = 32'h30000,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  // Handshake: if_req/ls_req are held by the requester until the matching one-cycle
  // done pulse (or, for IF, a flush); data outputs are valid only while done is high.

  localparam logic [2:0] FETCH_N = 3'(FETCH_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic        last_ls_q, last_ls_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        iss_q, iss_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mem_a_q;

  logic [31:0] mem_a_c;
  logic [7:0]  mem_dout_c;
  logic        mem_wr_c;
  logic        if_done_c, ls_done_c;
  logic        if_cand, pick_ls;
  logic [2:0]  issue_idx;
  logic [31:0] wr_addr;
  logic        wr_stall;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    last_ls_d  = last_ls_q;
    addr_d     = addr_q;
    n_d        = n_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    iss_d      = iss_q;
    data_d     = data_q;
    mem_a_c    = 32'h0;
    mem_dout_c = 8'h0;
    mem_wr_c   = 1'b0;
    if_done_c  = 1'b0;
    ls_done_c  = 1'b0;

    // LS wins a tie unless it was the last one served, so neither side starves.
    if_cand   = if_req && !flush;
    pick_ls   = ls_req && (!if_cand || !last_ls_q);
    // In READ, cnt_q counts captured bytes and iss_q marks one byte still on its way back.
    issue_idx = cnt_q + {2'b00, iss_q};
    wr_addr   = addr_q + {29'h0, cnt_q};
    wr_stall  = (wr_addr >= IO_BASE) && io_buffer_full;

    case (state_q)
      S_IDLE: begin
        if (pick_ls || if_cand) begin
          owner_ls_d = pick_ls;
          addr_d     = pick_ls ? ls_addr : if_addr;
          n_d        = pick_ls ? size_to_n(ls_size) : FETCH_N;
          wdata_d    = pick_ls ? ls_wdata : 32'h0;
          cnt_d      = 3'd0;
          iss_d      = 1'b0;
          data_d     = 32'h0;
          state_d    = (pick_ls && ls_wr) ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (!owner_ls_q && flush) begin
          state_d   = S_IDLE;
          last_ls_d = 1'b0;
          iss_d     = 1'b0;
        end else begin
          if (iss_q) begin
            data_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
            cnt_d = cnt_q + 3'd1;
          end
          if (issue_idx < n_q) begin
            mem_a_c = addr_q + {29'h0, issue_idx};
            iss_d   = 1'b1;
          end else begin
            iss_d = 1'b0;
          end
          if (iss_q && ((cnt_q + 3'd1) == n_q)) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        mem_a_c    = wr_addr;
        mem_dout_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        mem_wr_c   = !wr_stall;
        if (!wr_stall) begin
          cnt_d = cnt_q + 3'd1;
          if ((cnt_q + 3'd1) == n_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        last_ls_d = owner_ls_q;
        if (owner_ls_q) ls_done_c = 1'b1;
        else            if_done_c = !flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With rdy low the address is held so the RAM keeps returning the byte still owed.
  assign mem_a    = rdy ? mem_a_c : mem_a_q;
  assign mem_wr   = rdy & mem_wr_c;
  assign mem_dout = rdy ? mem_dout_c : 8'h0;
  assign if_done  = rdy & if_done_c;
  assign ls_done  = rdy & ls_done_c;
  assign if_data  = if_done ? data_q : 32'h0;
  assign ls_rdata = ls_done ? data_q : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_ls_q <= 1'b0;
      last_ls_q  <= 1'b0;
      addr_q     <= 32'h0;
      n_q        <= 3'd0;
      wdata_q    <= 32'h0;
      cnt_q      <= 3'd0;
      iss_q      <= 1'b0;
      data_q     <= 32'h0;
      mem_a_q    <= 32'h0;
    end else if (rdy) begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      last_ls_q  <= last_ls_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      iss_q      <= iss_d;
      data_q     <= data_d;
      mem_a_q    <= mem_a_c;
    end
  end

endmodule
